des_cbc_sequencer: RTL and testbench

//  CBC chaining front-end placed directly upstream of the DES core (DES_top).

---
 rtl/des_cbc_sequencer_if.sv | 27 ++
 rtl/des_cbc_sequencer.sv | 110 +++++++++++
 tb/tb_des_cbc_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_cbc_sequencer_if.sv
// Block-level bus of the CBC sequencer: plaintext input, DES core side and ciphertext output.
// The sequencer uses the slave modport; the environment around it uses the master modport.
interface des_cbc_sequencer_if;
    logic        iv_load;
    logic [63:0] iv;
    logic [63:0] key_in;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_block;
    logic [63:0] core_pt;
    logic [63:0] core_key;
    logic [63:0] core_ct;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_block;
    logic        busy;

    modport slave (
        input  iv_load, iv, key_in, in_valid, in_block, core_ct, out_ready,
        output in_ready, core_pt, core_key, out_valid, out_block, busy
    );

    modport master (
        output iv_load, iv, key_in, in_valid, in_block, core_ct, out_ready,
        input  in_ready, core_pt, core_key, out_valid, out_block, busy
    );
endinterface

// File: rtl/des_cbc_sequencer.sv
// CBC chaining front-end for a fixed-latency DES core: one block in flight,
// plaintext XORed with the chain value, ciphertext captured after CORE_LAT cycles.
module des_cbc_sequencer #(
    parameter int CORE_LAT = 16,
    parameter int CNT_W    = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    des_cbc_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CORE_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_t           r_state;
    logic [63:0]      r_chain;
    logic [63:0]      r_core_pt;
    logic [63:0]      r_core_key;
    logic [63:0]      r_out_block;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic [63:0]      w_chain_eff;

    function automatic logic [63:0] f_cbc_mix(input logic [63:0] blk, input logic [63:0] chain);
        return blk ^ chain;
    endfunction

    // An IV loaded in the same cycle as a block must already apply to that block.
    always_comb begin
        w_chain_eff = r_chain;
        if (bus.iv_load) begin
            w_chain_eff = bus.iv;
        end else begin
            w_chain_eff = r_chain;
        end
    end

    // Sequencer FSM with all outputs held in registers.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_chain     <= 64'h0;
            r_core_pt   <= 64'h0;
            r_core_key  <= 64'h0;
            r_out_block <= 64'h0;
            r_cnt       <= CNT_ZERO;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.iv_load) begin
                        r_chain <= bus.iv;
                    end
                    if (bus.in_valid) begin
                        r_core_pt  <= f_cbc_mix(bus.in_block, w_chain_eff);
                        r_core_key <= bus.key_in;
                        r_cnt      <= CNT_INIT;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Core inputs stay frozen; the last count captures the ciphertext.
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_out_block <= bus.core_ct;
                        r_chain     <= bus.core_ct;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= CNT_ZERO;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.core_pt   = r_core_pt;
    assign bus.core_key  = r_core_key;
    assign bus.out_valid = r_out_valid;
    assign bus.out_block = r_out_block;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_des_cbc_sequencer.sv
// Directed bench for des_cbc_sequencer: CORE_LAT=16 and CORE_LAT=1 instances,
// each fed by a behavioural DES core that only shows valid ciphertext after CORE_LAT stable cycles.
module tb_des_cbc_sequencer;

    localparam logic [63:0] KA  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KB  = 64'h0E329232EA6D0D73;
    localparam logic [63:0] BAD = 64'hBAD0BAD0BAD0BAD0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    des_cbc_sequencer_if bus_a();
    des_cbc_sequencer_if bus_b();

    des_cbc_sequencer #(.CORE_LAT(16), .CNT_W(8)) u_dut_a (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus_a)
    );

    des_cbc_sequencer #(.CORE_LAT(1), .CNT_W(8)) u_dut_b (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus_b)
    );

    // ---------------- behavioural DES ----------------
    int ip_t [0:63] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                        62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                        57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                        61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    int fp_t [0:63] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                        38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                        36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                        34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    int p_t [0:31]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                        2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    int pc1_t [0:55] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                         10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                         63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                         14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int pc2_t [0:47] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                         41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    int sh_t [0:15] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    logic [255:0] sbox_t [0:7] = '{
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71ED26F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

    function automatic logic [63:0] des_enc(input logic [63:0] pt, input logic [63:0] key);
        logic [55:0]  cd;
        logic [27:0]  c, d;
        logic [47:0]  ks [0:15];
        logic [63:0]  ipv, pre, ct;
        logic [31:0]  l, r, f, s, tmp;
        logic [47:0]  e, x;
        logic [5:0]   six;
        logic [255:0] sb;
        int           pos;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-pc1_t[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int rr = 0; rr < 16; rr++) begin
            for (int n = 0; n < sh_t[rr]; n++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[rr][47-i] = cd[56-pc2_t[i]];
        end
        for (int i = 0; i < 64; i++) ipv[63-i] = pt[64-ip_t[i]];
        l = ipv[63:32];
        r = ipv[31:0];
        for (int rr = 0; rr < 16; rr++) begin
            for (int g = 0; g < 8; g++) begin
                for (int j = 0; j < 6; j++) begin
                    pos = 4*g + j;
                    if (pos == 0)  pos = 32;
                    if (pos == 33) pos = 1;
                    e[47-(6*g+j)] = r[32-pos];
                end
            end
            x = e ^ ks[rr];
            for (int g = 0; g < 8; g++) begin
                six = x[47-6*g -: 6];
                sb  = sbox_t[g];
                s[31-4*g -: 4] = sb[255-4*(({30'd0, six[5], six[0]})*16 + {28'd0, six[4:1]}) -: 4];
            end
            for (int i = 0; i < 32; i++) f[31-i] = s[32-p_t[i]];
            tmp = l ^ f;
            l   = r;
            r   = tmp;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) ct[63-i] = pre[64-fp_t[i]];
        return ct;
    endfunction

    // ---------------- core models: ciphertext valid only after LAT stable cycles ----------------
    logic [63:0] a_trk_pt, a_trk_key, b_trk_pt, b_trk_key;
    int          a_cnt = 0;
    int          b_cnt = 0;

    always @(posedge clk) begin
        a_cnt     <= (bus_a.core_pt === a_trk_pt && bus_a.core_key === a_trk_key) ? a_cnt + 1 : 1;
        a_trk_pt  <= bus_a.core_pt;
        a_trk_key <= bus_a.core_key;
        b_cnt     <= (bus_b.core_pt === b_trk_pt && bus_b.core_key === b_trk_key) ? b_cnt + 1 : 1;
        b_trk_pt  <= bus_b.core_pt;
        b_trk_key <= bus_b.core_key;
    end

    always @* begin
        int age_a;
        int age_b;
        age_a = (bus_a.core_pt === a_trk_pt && bus_a.core_key === a_trk_key) ? a_cnt + 1 : 1;
        age_b = (bus_b.core_pt === b_trk_pt && bus_b.core_key === b_trk_key) ? b_cnt + 1 : 1;
        bus_a.core_ct = (age_a >= 16) ? des_enc(bus_a.core_pt, bus_a.core_key) : BAD;
        bus_b.core_ct = (age_b >= 1)  ? des_enc(bus_b.core_pt, bus_b.core_key) : BAD;
    end

    // ---------------- helpers ----------------
    logic [63:0] chain_m, pt_m, ct_m;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic accept_a(input logic [63:0] blk, input logic ld, input logic [63:0] ivv);
        check("acc_in_ready", {63'd0, bus_a.in_ready}, 64'd1);
        bus_a.in_block = blk;
        bus_a.in_valid = 1'b1;
        bus_a.iv_load  = ld;
        bus_a.iv       = ivv;
        pt_m = blk ^ (ld ? ivv : chain_m);
        if (ld) chain_m = ivv;
        tick();
        bus_a.in_valid = 1'b0;
        bus_a.iv_load  = 1'b0;
        check("acc_core_pt", bus_a.core_pt, pt_m);
        check("acc_core_key", bus_a.core_key, KA);
        check("acc_busy", {63'd0, bus_a.busy}, 64'd1);
        check("acc_in_ready_low", {63'd0, bus_a.in_ready}, 64'd0);
    endtask

    // Waits (bounded) for OUT_VALID and checks latency and ciphertext against the model.
    task automatic finish_a(input string tag);
        int n;
        n = 0;
        while (bus_a.out_valid !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        ct_m    = des_enc(pt_m, KA);
        chain_m = ct_m;
        check({tag, "_latency"}, 64'(n), 64'd16);
        check({tag, "_out_block"}, bus_a.out_block, ct_m);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [63:0] pb [0:3];
        logic [63:0] expb [0:3];
        logic [63:0] chain_b;
        int          acc_cyc [0:3];
        int          k, n_out, cyc, vcount;
        logic        was_ready;

        bus_a.iv_load = 1'b0; bus_a.iv = 64'h0; bus_a.key_in = KA;
        bus_a.in_valid = 1'b0; bus_a.in_block = 64'h0; bus_a.out_ready = 1'b1;
        bus_b.iv_load = 1'b0; bus_b.iv = 64'h0; bus_b.key_in = KB;
        bus_b.in_valid = 1'b0; bus_b.in_block = 64'h0; bus_b.out_ready = 1'b1;
        chain_m = 64'h0;

        // reset state
        rst_n = 1'b0;
        tick(); tick();
        check("rst_in_ready", {63'd0, bus_a.in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, bus_a.out_valid}, 64'd0);
        check("rst_busy", {63'd0, bus_a.busy}, 64'd0);
        check("rst_core_pt", bus_a.core_pt, 64'h0);
        check("rst_core_key", bus_a.core_key, 64'h0);
        check("rst_out_block", bus_a.out_block, 64'h0);
        check("rst_b_in_ready", {63'd0, bus_b.in_ready}, 64'd1);
        rst_n = 1'b1;
        tick();

        // T1: first block with IV=0 equals ECB
        accept_a(64'h0123456789ABCDEF, 1'b1, 64'h0);
        check("t1_core_pt", bus_a.core_pt, 64'h0123456789ABCDEF);
        finish_a("t1");
        check("t1_known_ct", bus_a.out_block, 64'h85E813540F0AB405);
        tick();
        check("t1_out_valid_drop", {63'd0, bus_a.out_valid}, 64'd0);
        check("t1_idle_ready", {63'd0, bus_a.in_ready}, 64'd1);

        // T2: chaining from the previous ciphertext; T3 backpressure on the output
        bus_a.out_ready = 1'b0;
        accept_a(64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h0);
        check("t2_core_pt", bus_a.core_pt, 64'h7A17ECABF0F54BFA);
        finish_a("t2");
        bus_a.in_valid = 1'b1; bus_a.in_block = 64'h5555AAAA5555AAAA;
        bus_a.iv_load  = 1'b1; bus_a.iv = 64'hFFFFFFFFFFFFFFFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_out_valid", {63'd0, bus_a.out_valid}, 64'd1);
            check("t3_out_block", bus_a.out_block, ct_m);
            check("t3_in_ready", {63'd0, bus_a.in_ready}, 64'd0);
        end
        bus_a.in_valid = 1'b0; bus_a.iv_load = 1'b0;
        bus_a.out_ready = 1'b1;
        tick();
        check("t3_release_valid", {63'd0, bus_a.out_valid}, 64'd0);
        check("t3_release_ready", {63'd0, bus_a.in_ready}, 64'd1);
        check("t3_release_busy", {63'd0, bus_a.busy}, 64'd0);

        // T4: IV_LOAD during WAIT is ignored
        accept_a(64'h0011223344556677, 1'b0, 64'h0);
        bus_a.iv_load = 1'b1; bus_a.iv = 64'hFFFFFFFFFFFFFFFF;
        finish_a("t4a");
        bus_a.iv_load = 1'b0;
        tick();
        accept_a(64'h8899AABBCCDDEEFF, 1'b0, 64'h0);
        finish_a("t4b");
        tick();
        // IV_LOAD together with IN_VALID applies the new IV to this block
        accept_a(64'h1111111111111111, 1'b1, 64'h0F0F0F0F0F0F0F0F);
        check("t4c_core_pt", bus_a.core_pt, 64'h1E1E1E1E1E1E1E1E);
        finish_a("t4c");
        tick();

        // T5: reset mid-WAIT drops the block
        accept_a(64'hDEADBEEFCAFEF00D, 1'b0, 64'h0);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chain_m = 64'h0;
        check("t5_out_valid", {63'd0, bus_a.out_valid}, 64'd0);
        check("t5_out_block", bus_a.out_block, 64'h0);
        check("t5_core_pt", bus_a.core_pt, 64'h0);
        check("t5_core_key", bus_a.core_key, 64'h0);
        check("t5_busy", {63'd0, bus_a.busy}, 64'd0);
        check("t5_in_ready", {63'd0, bus_a.in_ready}, 64'd1);
        vcount = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus_a.out_valid === 1'b1) vcount++;
        end
        check("t5_no_out_valid", 64'(vcount), 64'd0);
        accept_a(64'h0123456789ABCDEF, 1'b0, 64'h0);
        check("t5_chain_zero_pt", bus_a.core_pt, 64'h0123456789ABCDEF);
        finish_a("t5");
        check("t5_known_ct", bus_a.out_block, 64'h85E813540F0AB405);
        tick();

        // T6: CORE_LAT=1 instance, four back-to-back blocks with OUT_READY high
        pb[0] = 64'h0000000000000000; pb[1] = 64'h0123456789ABCDEF;
        pb[2] = 64'hA5A5A5A55A5A5A5A; pb[3] = 64'hFFFFFFFF00000000;
        chain_b = 64'h0;
        for (int j = 0; j < 4; j++) begin
            expb[j] = des_enc(pb[j] ^ chain_b, KB);
            chain_b = expb[j];
        end
        k = 0; n_out = 0; cyc = 0;
        for (int j = 0; j < 4; j++) acc_cyc[j] = 0;
        bus_b.in_block = pb[0];
        bus_b.in_valid = 1'b1;
        while (n_out < 4 && cyc < 60) begin
            was_ready = bus_b.in_ready;
            tick();
            cyc++;
            if (was_ready === 1'b1 && k < 4) begin
                acc_cyc[k] = cyc;
                k++;
                if (k < 4) bus_b.in_block = pb[k];
                else       bus_b.in_valid = 1'b0;
            end
            if (bus_b.out_valid === 1'b1 && n_out < 4) begin
                check("t6_out_block", bus_b.out_block, expb[n_out]);
                n_out++;
            end
        end
        bus_b.in_valid = 1'b0;
        check("t6_accepts", 64'(k), 64'd4);
        check("t6_outputs", 64'(n_out), 64'd4);
        for (int j = 1; j < 4; j++) begin
            check("t6_spacing", 64'(acc_cyc[j] - acc_cyc[j-1]), 64'd3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
